// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parameterised single-clock FIFO
// and the per-channel data widths it replaces.
package fifo_pkg;

  localparam int LOAD_W  = 22;
  localparam int STORE_W = 54;
  localparam int RESP_W  = 45;

  // Pointer carries one extra wrap bit above the address.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array, one synchronous write port and one read port.
// Read port is registered by default, combinational when FIFO_FWFT_EN is defined.
module fifo_mem #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
`ifndef FIFO_FWFT_EN
  input  logic             rst,
  input  logic             rd_en,
`else
  input  logic             rd_valid,
`endif
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; forced to zero while the FIFO is empty.
  always_comb begin
    rd_data = '0;
    if (rd_valid) rd_data = mem[rd_addr];
  end
`else
  // Non-blocking read returns the old word even when the same address is written this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy count, threshold flags, flush
// and sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through output.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = STORE_W,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       write_enable,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       read_enable,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty_signal,
  output logic                       full_signal,
  output logic                       almost_full_signal,
  output logic                       almost_empty_signal,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow_error,
  output logic                       underflow_error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop_ok, push_ok;
  logic             mem_wr, mem_rd;

  assign empty_signal        = (count == CNT_W'(0));
  assign full_signal         = (count == CNT_W'(DEPTH));
  assign almost_full_signal  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty_signal = (count <= CNT_W'(AE_THRESH));

  // Handshake: a request is taken on the rising edge where it is held high and the
  // matching *_ok term is true; a pop frees a slot so a push into a full FIFO is
  // taken alongside it. There is no ready output: the master watches the flags.
  assign pop_ok  = read_enable & ~empty_signal;
  assign push_ok = write_enable & (~full_signal | pop_ok);

  // clear wins over both transfers, so memory and data_out are left untouched.
  assign mem_wr = push_ok & ~clear;
  assign mem_rd = pop_ok & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else if (clear) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (write_enable & full_signal & ~pop_ok) overflow_error  <= 1'b1;
      if (read_enable & empty_signal)           underflow_error <= 1'b1;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
`ifndef FIFO_FWFT_EN
    .rst      (reset),
    .rd_en    (mem_rd),
`else
    .rd_valid (~empty_signal),
`endif
    .wr_en    (mem_wr),
    .wr_addr  (wr_ptr[AW-1:0]),
    .wr_data  (data_in),
    .rd_addr  (rd_ptr[AW-1:0]),
    .rd_data  (data_out)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (WIDTH=54, DEPTH=8).
// Works in both read modes; FIFO_FWFT_EN selects the matching data_out expectation.
module tb_param_sync_fifo;

  localparam int W  = 54;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset, clear, write_enable, read_enable;
  logic [W-1:0]  data_in, data_out;
  logic          empty_signal, full_signal, almost_full_signal, almost_empty_signal;
  logic [CW-1:0] count;
  logic          overflow_error, underflow_error;

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk                 (clk),
    .reset               (reset),
    .clear               (clear),
    .write_enable        (write_enable),
    .data_in             (data_in),
    .read_enable         (read_enable),
    .data_out            (data_out),
    .empty_signal        (empty_signal),
    .full_signal         (full_signal),
    .almost_full_signal  (almost_full_signal),
    .almost_empty_signal (almost_empty_signal),
    .count               (count),
    .overflow_error      (overflow_error),
    .underflow_error     (underflow_error)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard state
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];
  int           m_cnt = 0;
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;
  logic [W-1:0] m_dout = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    logic [W-1:0] exp_dout;
`ifdef FIFO_FWFT_EN
    exp_dout = (exp_q.size() > 0) ? exp_q[0] : '0;
`else
    exp_dout = m_dout;
`endif
    check({tag, ".count"}, 64'(count), 64'(m_cnt));
    check({tag, ".empty"}, 64'(empty_signal), 64'(m_cnt == 0));
    check({tag, ".full"},  64'(full_signal), 64'(m_cnt == D));
    check({tag, ".afull"}, 64'(almost_full_signal), 64'(m_cnt >= AF));
    check({tag, ".aempty"}, 64'(almost_empty_signal), 64'(m_cnt <= AE));
    check({tag, ".ovf"}, 64'(overflow_error), 64'(m_ovf));
    check({tag, ".udf"}, 64'(underflow_error), 64'(m_udf));
    check({tag, ".dout"}, 64'(data_out), 64'(exp_dout));
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
    exp_q.delete();
  endtask

  // driver: apply one cycle of requests, update the model, sample 1 time unit after the edge
  task automatic step(input bit we, input logic [W-1:0] din, input bit re);
    bit pop_ok, push_ok;
    write_enable = we;
    data_in      = din;
    read_enable  = re;
    pop_ok  = re && (m_cnt > 0);
    push_ok = we && ((m_cnt < D) || pop_ok);
    if (we && (m_cnt == D) && !pop_ok) m_ovf = 1'b1;
    if (re && (m_cnt == 0))            m_udf = 1'b1;
    if (pop_ok)  m_dout = exp_q.pop_front();
    if (push_ok) exp_q.push_back(din);
    m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    exp_q.delete();
  endtask

  bit wrap_we[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  bit wrap_re[10] = '{0, 0, 1, 1, 1, 1, 1, 0, 1, 1};

  initial begin
    reset        = 1'b1;
    clear        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = '0;
    #12;
    check_status("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // fill 1..8, then one push too many
    for (int i = 1; i <= D; i++) begin
      step(1'b1, W'(i), 1'b0);
      check_status($sformatf("fill%0d", i));
    end
    check("fill.count_hand", 64'(count), 64'd8);
    check("fill.full_hand", 64'(full_signal), 64'd1);
    step(1'b1, W'(9), 1'b0);
    check("ovf.flag_hand", 64'(overflow_error), 64'd1);
    check("ovf.count_hand", 64'(count), 64'd8);
    for (int i = 1; i <= D; i++) begin
      step(1'b0, '0, 1'b1);
      check_status($sformatf("drain%0d", i));
`ifndef FIFO_FWFT_EN
      check($sformatf("drain%0d.data_hand", i), 64'(data_out), 64'(i));
`endif
    end
    check("drain.empty_hand", 64'(empty_signal), 64'd1);

    // full FIFO: simultaneous push 0xAA and pop
    for (int i = 1; i <= D; i++) step(1'b1, W'(100 + i), 1'b0);
    step(1'b1, W'('hAA), 1'b1);
    check_status("fullboth");
`ifndef FIFO_FWFT_EN
    check("fullboth.oldest_hand", 64'(data_out), 64'd101);
`endif
    check("fullboth.count_hand", 64'(count), 64'd8);
    for (int i = 1; i <= D; i++) begin
      step(1'b0, '0, 1'b1);
      check_status($sformatf("after_aa%0d", i));
    end
`ifndef FIFO_FWFT_EN
    check("last_aa_hand", 64'(data_out), 64'hAA);
`endif

    // underflow on empty, then clear
    step(1'b0, '0, 1'b1);
    check_status("udf");
    check("udf.flag_hand", 64'(underflow_error), 64'd1);
    do_clear();
    check_status("clear");
    check("clear.udf_hand", 64'(underflow_error), 64'd0);
    check("clear.ovf_hand", 64'(overflow_error), 64'd0);

    // wrap-around with count held in 2..5
    for (int i = 0; i < 3; i++) step(1'b1, W'(500 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(wrap_we[i % 10], W'(7 + 3 * i), wrap_re[i % 10]);
      check_status($sformatf("wrap%0d", i));
    end

    // asynchronous reset mid-burst at count=5
    do_clear();
    for (int i = 0; i < 5; i++) step(1'b1, W'(900 + i), 1'b0);
    check("preburst.count_hand", 64'(count), 64'd5);
    write_enable = 1'b1;
    read_enable  = 1'b1;
    data_in      = W'('h77);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_status("async_rst");
    check("async_rst.count_hand", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = '0;
    reset        = 1'b0;
    check_status("async_rst_hold");
    step(1'b1, W'('h55), 1'b0);
    step(1'b0, '0, 1'b1);
    check_status("post_rst");
`ifndef FIFO_FWFT_EN
    check("post_rst.data_hand", 64'(data_out), 64'h55);
`endif

    // push into empty and pop back (fall-through visible in FWFT builds)
    step(1'b1, W'('h15), 1'b0);
    check_status("single_push");
`ifdef FIFO_FWFT_EN
    check("fwft.head_hand", 64'(data_out), 64'h15);
`endif
    step(1'b0, '0, 1'b1);
    check_status("single_pop");
`ifdef FIFO_FWFT_EN
    check("fwft.zero_hand", 64'(data_out), 64'h0);
`else
    check("single_pop.data_hand", 64'(data_out), 64'h15);
`endif
    check("single_pop.empty_hand", 64'(empty_signal), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
- Generic single-clock FIFO. It replaces the fixed-width load, store and response FIFOs (22/54/45-bit) between the processor pipeline and the bus master/slave.
- Width, depth and almost-full/almost-empty thresholds are parameters.
- Adds an occupancy count, threshold flags, a synchronous flush, and sticky overflow/underflow error flags.
- One instance per channel. The master drives read_enable from empty_signal, as it does today.

Parameters:
- WIDTH, 54, data word width in bits; must be >= 1.
- DEPTH, 8, number of entries; must be a power of two and >= 2.
- AF_THRESH, 6, almost_full_signal asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2, almost_empty_signal asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush.
- write_enable  in  1  push request.
- data_in  in  WIDTH  push data.
- read_enable  in  1  pop request.
- data_out  out  WIDTH  popped word.
- empty_signal  out  1  count == 0.
- full_signal  out  1  count == DEPTH.
- almost_full_signal  out  1  count >= AF_THRESH.
- almost_empty_signal  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow_error  out  1  sticky; a push was attempted while full and not accepted.
- underflow_error  out  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and count go to 0; data_out goes to 0.
  - empty_signal=1, almost_empty_signal=1, full_signal=0, almost_full_signal=0 (given AF_THRESH >= 1).
  - Both error flags go to 0. Memory contents are not reset.
  - If reset asserts mid-operation, any push or pop in flight is discarded.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Full means the addresses are equal and the wrap bits differ. Empty means the pointers are identical.
  - count is a separate register, kept consistent with the pointers.
- Acceptance rules:
  - pop_ok = read_enable & ~empty_signal.
  - push_ok = write_enable & (~full_signal | pop_ok).
- Simultaneous push and pop:
  - When full, both are accepted and count is unchanged. The pop reads the old word at the shared address; the push overwrites it in the same edge.
  - When empty, only the push is accepted and underflow_error is set.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Status flags:
  - empty, full, almost_full and almost_empty are combinational decodes of the count register.
  - They are therefore valid the cycle after the edge that changes count.
- Read latency (default mode):
  - On pop_ok, data_out <= mem[rd_addr] at the edge; the word is valid from the next cycle.
  - data_out holds its value when no pop occurs.
- Error flags:
  - overflow_error sets when write_enable & full_signal & ~pop_ok.
  - underflow_error sets when read_enable & empty_signal.
  - Both hold until reset or clear.
- clear:
  - Synchronously zeroes the pointers, count and both error flags.
  - It takes priority over a push or pop in the same cycle. data_out is not changed.
- Wrap-around: address bits roll from DEPTH-1 to 0 and the wrap bit toggles.
- Unlatched write: data_in is ignored on a rejected push.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_addr] combinationally whenever ~empty_signal. read_enable acknowledges and advances the pointer.
  - A word pushed into an empty FIFO appears on data_out the cycle after the push edge.
  - data_out is 0 while empty.
- Undefined: registered-output behaviour as described under Behaviour.

Decomposition:
- Shared package fifo_pkg holds:
  - the ptr_w/cnt_w width constants or functions derived via $clog2;
  - the per-channel WIDTH constants: LOAD_W=22, STORE_W=54, RESP_W=45.
- One natural sub-module, fifo_mem:
  - WIDTH x DEPTH register array with one synchronous write port;
  - one read port, registered or combinational depending on FIFO_FWFT_EN.
- Control logic (pointers, count, flags) stays in param_sync_fifo.

Test Plan:
1. WIDTH=54, DEPTH=8. Push 1..8 with no pops:
   - count reaches 8; full_signal=1; almost_full_signal=1 from count=6.
   - A 9th push sets overflow_error=1 and count stays 8.
   - Popping 8 times returns 1..8 in order, each valid one cycle after its pop; empty_signal=1 afterwards.
2. Full FIFO, push 0xAA together with a pop:
   - The pop returns the oldest word; count stays 8.
   - After 8 further pops, 0xAA is the last word out.
3. Empty FIFO, pop only: underflow_error=1, data_out unchanged, count=0. Then pulse clear for one cycle: both error flags return to 0.
4. Wrap-around: run 20 interleaved push/pop cycles holding count between 2 and 5. The output sequence must equal the input sequence; almost_empty_signal tracks count <= 2.
5. Assert reset asynchronously mid-burst with count=5:
   - Flags and count go to reset values immediately, without waiting for a clock edge.
   - The next push followed by a pop returns only the new word.
6. With FIFO_FWFT_EN defined:
   - Push 0x15 into the empty FIFO; data_out=0x15 the next cycle without read_enable.
   - Pop it; data_out returns to 0 and empty_signal=1.
